// File: rtl/display_pkg.sv
// Shared types and constants for the display scan/convert path.
package display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  localparam int unsigned MAX_MAG    = 999;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_ITERS  = 10;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned BIN_W      = 10;
  localparam int unsigned ITER_W     = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NIB_W      = 4;

  // Double-dabble nibble correction applied before each shift.
  function automatic logic [NIB_W-1:0] dabble_adj(input logic [NIB_W-1:0] n);
    return (n >= NIB_W'(5)) ? n + NIB_W'(3) : n;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Conversion handshake plus digit/scan outputs toward displayMux.
interface display_scan_ctrl_if
  import display_pkg::*;
#(
  parameter int unsigned VAL_W = 11
);
  logic [VAL_W-1:0]      value;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [DIGIT_W-1:0]    digit;
  logic [NUM_DIGITS-1:0] anode;
  logic [NIB_W-1:0]      num2;
  logic [NIB_W-1:0]      num1;
  logic [NIB_W-1:0]      num0;
  logic                  neg;

  modport master (output value, start,
                  input  busy, done, digit, anode, num2, num1, num0, neg);
  modport slave  (input  value, start,
                  output busy, done, digit, anode, num2, num1, num0, neg);
endinterface

// File: rtl/display_scan_ctrl_bin2bcd_step.sv
// One combinational double-dabble iteration over a {bcd, bin} shift register.
module bin2bcd_step
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_c,
  output logic [BIN_W-1:0] bin_c
);
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj            = {dabble_adj(bcd_i[11:8]), dabble_adj(bcd_i[7:4]), dabble_adj(bcd_i[3:0])};
    {bcd_c, bin_c} = {adj, bin_i} << 1;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Signed tenths -> sign + 3 BCD digits converter with continuous 4-digit scan.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned VAL_W       = 11
)(
  input  logic                 clk,
  input  logic                 reset,
  display_scan_ctrl_if.slave   bus
);
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned MAG_W = VAL_W + 1;

  conv_state_t           state_q, state_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic                  sign_q, sign_d;
  logic [NIB_W-1:0]      num2_q, num2_d, num1_q, num1_d, num0_q, num0_d;
  logic                  neg_q, neg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  logic [BCD_W-1:0]      step_bcd;
  logic [BIN_W-1:0]      step_bin;
  logic [MAG_W-1:0]      val_ext, mag_full;
  logic [BIN_W-1:0]      mag_clamp;

  bin2bcd_step u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_c (step_bcd),
    .bin_c (step_bin)
  );

  // Magnitude with one extra bit so the most negative input negates cleanly.
  always_comb begin
    val_ext   = {bus.value[VAL_W-1], bus.value};
    mag_full  = bus.value[VAL_W-1] ? -val_ext : val_ext;
    mag_clamp = (mag_full > MAG_W'(MAX_MAG)) ? BIN_W'(MAX_MAG) : BIN_W'(mag_full);
  end

  // Prescaler and digit-select scan, free-running.
  always_comb begin
    pre_d   = pre_q + PRE_W'(1);
    digit_d = digit_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d   = '0;
      digit_d = digit_q + DIGIT_W'(1);
    end
    anode_d = ~(NUM_DIGITS'(1) << digit_d);
  end

  // Conversion sequencer; digits are only written in COMMIT.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    sign_d  = sign_q;
    num2_d  = num2_q;
    num1_d  = num1_q;
    num0_d  = num0_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = mag_clamp;
          bcd_d   = '0;
          sign_d  = bus.value[VAL_W-1];
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d  = step_bcd;
        bin_d  = step_bin;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BCD_ITERS - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        num2_d  = bcd_q[11:8];
        num1_d  = bcd_q[7:4];
        num0_d  = bcd_q[3:0];
        neg_d   = sign_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      sign_q  <= 1'b0;
      num2_q  <= '0;
      num1_q  <= '0;
      num0_q  <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      digit_q <= '0;
      anode_q <= ~(NUM_DIGITS'(1));
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      sign_q  <= sign_d;
      num2_q  <= num2_d;
      num1_q  <= num1_d;
      num0_q  <= num0_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      digit_q <= digit_d;
      anode_q <= anode_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.digit = digit_q;
  assign bus.anode = anode_q;
  assign bus.num2  = num2_q;
  assign bus.num1  = num1_q;
  assign bus.num0  = num0_q;
  assign bus.neg   = neg_q;
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the 4-digit seven-segment display path: it converts a signed fixed-point value (tenths) into sign plus three BCD digits and drives the digit-select scan that feeds `displayMux`. Digit registers update atomically at the end of each conversion, so the scan never shows a partially converted value. It sits between the channel-strip level/parameter logic and `displayMux`/segment decoder.

## Interface
Parameters:
- `REFRESH_DIV`, 50000: clock cycles each digit stays selected; must be ≥ 2.
- `VAL_W`, 11: width of signed input value, in units of 0.1.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  VAL_W  signed two's-complement value to display, LSB = 0.1.
- `start`  in  1  request a conversion of `value`.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; new digits are committed.
- `digit`  out  2  scan select to `displayMux`: 3 = sign, 2/1/0 = digits.
- `anode`  out  4  active-low digit enable, `anode = ~(1 << digit)`.
- `num2`, `num1`, `num0`  out  4 each  BCD tens, units and tenths.
- `neg`  out  1  sign flag to `displayMux`.

## Operation
- Scan: prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and `digit` increments mod 4 (3→0). The scan runs continuously, independent of conversion.
- Conversion FSM states:
  - IDLE: `start` is sampled here. On `start`, capture `value` and go to SHIFT.
  - SHIFT: exactly 10 double-dabble iterations, one per cycle. In each iteration, add 3 to any BCD nibble ≥ 5, then shift left by 1.
  - COMMIT: write `num2`, `num1`, `num0`, `neg`; then return to IDLE.
- Magnitude: `neg = value[VAL_W-1]`. Magnitude = |value|, clamped to 999 (10 bits). −1024 clamps to 999 with `neg=1`. Zero yields `neg=0`.
- `start` is ignored while `busy`; there is no queueing.
- `busy = (state != IDLE)`.
- Outputs `num*`/`neg` hold their last committed value between conversions.

## Timing
- Reset values: `digit=0`, prescaler=0, `anode=4'b1110`, `num2=num1=num0=0`, `neg=0`, `busy=0`, `done=0`, state IDLE.
- Conversion latency: `start` sampled at edge E.
  - `busy` rises at E.
  - Iterations occur at edges E+1..E+10.
  - COMMIT updates `num*`/`neg` at edge E+11, `done` is high for the cycle after E+11, and `busy` falls at E+11.
- The earliest next accepted `start` is sampled at E+12. A `start` held high continuously therefore restarts every 12 cycles.
- `value` is sampled only at E; changes afterwards do not affect the conversion in progress.
- `digit` and `anode` change on the same edge, REFRESH_DIV cycles apart.
- A commit coinciding with a digit change is legal; the mux sees new data for the new digit.
- `reset` asserted mid-conversion aborts it: no `done`, and outputs return to reset values on the next edge.

## Structure
- Package `display_pkg`:
  - FSM state enum `conv_state_t` {IDLE, SHIFT, COMMIT}.
  - `MAX_MAG = 999`, `NUM_DIGITS = 4`, `BCD_ITERS = 10`.
- Sub-module `bin2bcd_step`: combinational single double-dabble iteration (12-bit BCD + 10-bit binary in → out). It is instantiated once and used iteratively by the FSM.
- Prescaler, scan counter and FSM live in `display_scan_ctrl`.

## Test plan
- Reset then idle, with `REFRESH_DIV=4`: `digit` sequence 0,1,2,3,0 changing every 4 cycles; `anode` 1110,1101,1011,0111,1110; `num*=0`, `neg=0`.
- `value=+123` pulse `start`: `busy` high 11 cycles, `done` one cycle at E+11, then `num2=1`, `num1=2`, `num0=3`, `neg=0`.
- `value=-457`: `num2=4`, `num1=5`, `num0=7`, `neg=1`. `value=-1024` and `+1023`: 9,9,9 with `neg=1`/`0` respectively.
- `start` held high for 30 cycles with `value` changing every cycle: exactly the values present at accepted starts (cycles 0, 12, 24) are converted; `done` pulses at 11 and 23.
- `reset` asserted at E+5 of a conversion of 888: no `done`; `num*=0`, `neg=0`, `busy=0`, `digit=0`, `anode=1110` after the edge.
- `value=0`: `num*=0`, `neg=0`; a commit landing on a `digit` wrap edge shows no glitch on `anode`.
